uart_rx: RTL and testbench

- 8N1 UART receiver; the downstream counterpart of uart_tx.
- Consumes the serial line that uart_tx drives on data_tx, recovers each byte, and presents it as a parallel word with a one-cycle valid strobe.
- Runs on the same single clock as uart_tx, with the same bit period in clock cycles.
- Reports framing errors.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, start-bit validation at half a bit,
// centre sampling of data and stop bits, one-cycle data_valid / frame_err strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic                 sync1_r;
  logic                 rx_s;
  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [IW-1:0]        idx_r;
  logic [IW-1:0]        idx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic [DATA_BITS:0]   shift_in_s;
  logic [DATA_BITS-1:0] data_r;
  logic [DATA_BITS-1:0] data_s;
  logic                 valid_r;
  logic                 valid_s;
  logic                 ferr_r;
  logic                 ferr_s;

  // New bits enter at the MSB end so the first (LSB) bit ends up in bit 0.
  assign shift_in_s = {rx_s, shift_r};

  // Synchronizer and all receiver state; the flops reset to the idle line level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      sync1_r <= rx_in;
      rx_s    <= sync1_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      ferr_r  <= ferr_s;
    end
  end

  // Next-state, counters, shift register and strobe decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    data_s  = data_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        idx_s = '0;
        if (!rx_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = '0;
          idx_s = '0;
          if (!rx_s) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == BIT_END) begin
          cnt_s   = '0;
          shift_s = shift_in_s[DATA_BITS:1];
          if (idx_r == LAST_IDX) begin
            idx_s   = '0;
            state_s = STOP;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == BIT_END) begin
          cnt_s = '0;
          if (rx_s) begin
            data_s  = shift_r;
            valid_s = 1'b1;
            state_s = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = WAIT_HIGH;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      // A held-low (break) line must not be re-decoded as new frames.
      WAIT_HIGH: begin
        cnt_s = '0;
        if (rx_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HIGH;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        idx_s   = '0;
      end
    endcase
  end

  assign data       = data_r;
  assign data_valid = valid_r;
  assign frame_err  = ferr_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver queues the outcome each frame must produce,
// an independent monitor pops and checks every strobe against it.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int NB  = 8;
  // Edges from the first low sample of the start bit to the strobe edge.
  localparam int LAT = CPB / 2 + (NB + 1) * CPB + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_in = 1'b1;
  logic [NB-1:0] data;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [NB-1:0] bval;
    int unsigned   e0;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   valid_times[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [NB-1:0] held = '0;
  bit            mon_en = 1'b0;
  bit            prev_strobe = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h), cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame LSB first; the line is left at the stop-bit level.
  task automatic send_frame(input logic [NB-1:0] b, input bit stop_bit);
    exp_t e;
    e.is_err = !stop_bit;
    e.bval   = b;
    e.e0     = cyc + 1;
    exp_q.push_back(e);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < NB; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop_bit;
    tick(CPB);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      tick(1);
      t++;
    end
    chk(exp_q.size() == 0, "strobe_timeout", longint'(exp_q.size()), 0);
  endtask

  // Monitor: every strobe is matched against the oldest expected outcome.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid || frame_err) begin
        chk(!(data_valid && frame_err), "strobe_exclusive", longint'({data_valid, frame_err}), 1);
        chk(!prev_strobe, "strobe_width", 2, 1);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_strobe", longint'({data_valid, frame_err}), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(frame_err == e.is_err, "strobe_kind", longint'(frame_err), longint'(e.is_err));
          chk(cyc >= e.e0 + LAT - 1 && cyc <= e.e0 + LAT + 1, "latency",
              longint'(cyc) - longint'(e.e0), longint'(LAT));
          if (data_valid) begin
            chk(data == e.bval, "data", longint'(data), longint'(e.bval));
            held = e.bval;
            valid_times.push_back(cyc);
          end else begin
            chk(data == held, "err_data_keep", longint'(data), longint'(held));
          end
        end
      end else begin
        chk(data == held, "data_hold", longint'(data), longint'(held));
      end
      prev_strobe = data_valid || frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2);
    chk(data == '0, "reset_data", longint'(data), 0);
    chk(data_valid == 1'b0, "reset_valid", longint'(data_valid), 0);
    chk(frame_err == 1'b0, "reset_ferr", longint'(frame_err), 0);
    chk(busy == 1'b0, "reset_busy", longint'(busy), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    tick(5);

    // Single frame
    send_frame(8'h76, 1'b1);
    drain();
    tick(10);

    // Back-to-back frames, no idle gap
    base = valid_times.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    drain();
    chk(valid_times.size() == base + 3, "b2b_count", longint'(valid_times.size() - base), 3);
    if (valid_times.size() == base + 3) begin
      chk(valid_times[base+1] - valid_times[base] == CPB * (NB + 2), "b2b_spacing1",
          longint'(valid_times[base+1] - valid_times[base]), CPB * (NB + 2));
      chk(valid_times[base+2] - valid_times[base+1] == CPB * (NB + 2), "b2b_spacing2",
          longint'(valid_times[base+2] - valid_times[base+1]), CPB * (NB + 2));
    end
    tick(10);

    // Glitch rejection: 3-cycle low pulse
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(2);
    chk(busy == 1'b1, "glitch_busy_high", longint'(busy), 1);
    tick(20);
    chk(busy == 1'b0, "glitch_busy_low", longint'(busy), 0);
    tick(5);

    // Framing error with a held-low line
    send_frame(8'h3C, 1'b0);
    tick(25);
    chk(busy == 1'b1, "break_busy", longint'(busy), 1);
    tick(25);
    rx_in = 1'b1;
    tick(4);
    chk(busy == 1'b0, "break_release", longint'(busy), 0);
    chk(exp_q.size() == 0, "ferr_seen", longint'(exp_q.size()), 0);
    send_frame(8'h81, 1'b1);
    drain();
    tick(10);

    // Reset during data bit 4 of 0x55
    begin
      logic [NB-1:0] b;
      b = 8'h55;
      rx_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
        rx_in = b[i];
        tick(CPB);
      end
      rx_in = b[4];
      tick(CPB / 2);
    end
    reset = 1'b0;
    tick(1);
    chk(data == '0, "midreset_data", longint'(data), 0);
    chk(data_valid == 1'b0, "midreset_valid", longint'(data_valid), 0);
    chk(frame_err == 1'b0, "midreset_ferr", longint'(frame_err), 0);
    chk(busy == 1'b0, "midreset_busy", longint'(busy), 0);
    held = '0;
    reset = 1'b1;
    rx_in = 1'b1;
    tick(10);
    send_frame(8'hC3, 1'b1);
    drain();
    tick(10);

    // Randomized traffic with occasional framing errors
    for (int k = 0; k < 40; k++) begin
      bit err;
      err = ($urandom_range(0, 4) == 0);
      send_frame(NB'($urandom), !err);
      if (err) begin
        tick($urandom_range(0, 30));
        rx_in = 1'b1;
        tick($urandom_range(1, 20));
      end else begin
        tick($urandom_range(0, 20));
      end
    end
    drain();
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
